axis_stim_seq_ctrl: RTL and testbench

- Sequencer for the AXI-Stream stimulus generator (`axis_stim_syn_vwrap`).
- Issues `stim_start` pulses to run a programmed number of bursts; each burst is a programmed number of frames.
- Inserts a programmed idle gap between bursts.
- Passively monitors the generator's M_AXIS handshake to detect frame ends; reports progress, completion and errors.
- Sits beside the generator in test/bring-up designs; driven by a register block or testbench.

---
 rtl/axis_stim_pkg.sv | 17 +
 rtl/axis_stim_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_axis_stim_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_stim_pkg.sv
// axis_stim_pkg: shared state encoding and default widths for the AXI-Stream stimulus sequencer and generator wrapper
package axis_stim_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      RUN    = 3'd2,
      GAP    = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam int STIM_BURST_W        = 16;
   localparam int STIM_FRAME_W        = 8;
   localparam int STIM_GAP_W          = 16;
   localparam int STIM_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/axis_stim_seq_ctrl.sv
// axis_stim_seq_ctrl: runs bursts of frames on the stimulus generator with idle gaps; optional stall watchdog via STIM_CTRL_WATCHDOG_EN
module axis_stim_seq_ctrl
   import axis_stim_pkg::*;
#(
   parameter int BURST_W        = STIM_BURST_W,
   parameter int FRAME_W        = STIM_FRAME_W,
   parameter int GAP_W          = STIM_GAP_W,
   parameter int TIMEOUT_CYCLES = STIM_TIMEOUT_CYCLES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               go,
   input  logic               abort,
   input  logic [BURST_W-1:0] cfg_bursts,
   input  logic [FRAME_W-1:0] cfg_frames,
   input  logic [GAP_W-1:0]   cfg_gap,
   output logic               stim_start,
   input  logic               mon_tvalid,
   input  logic               mon_tready,
   input  logic               mon_tlast,
   output logic               busy,
   output logic               done,
   output logic [BURST_W-1:0] burst_cnt,
   output logic [FRAME_W-1:0] frame_cnt,
   output logic               err
);

   state_t             state;
   logic [BURST_W-1:0] bursts_q;
   logic [FRAME_W-1:0] frames_q;
   logic [GAP_W-1:0]   gap_q;
   logic [GAP_W-1:0]   gap_cnt;
   logic               hs;
   logic               eof;
   logic               go_ok;
   logic               wd_hit;
   logic [BURST_W-1:0] burst_nxt;
   logic [FRAME_W-1:0] frame_nxt;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   assign hs        = mon_tvalid & mon_tready;
   assign eof       = hs & mon_tlast;
   assign go_ok     = (state == IDLE) && go && !abort;
   assign busy      = (state != IDLE);
   assign burst_nxt = burst_cnt + 1'b1;
   assign frame_nxt = frame_cnt + 1'b1;

   // sequencer FSM; stim_start and done are registered alongside the state they belong to
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         stim_start <= 1'b0;
         done       <= 1'b0;
         burst_cnt  <= '0;
         frame_cnt  <= '0;
         bursts_q   <= '0;
         frames_q   <= '0;
         gap_q      <= '0;
         gap_cnt    <= '0;
      end else begin
         stim_start <= 1'b0;
         done       <= 1'b0;
         if (abort) begin
            if (state != IDLE) state <= IDLE;
         end else begin
            case (state)
               IDLE: if (go_ok) begin
                  bursts_q   <= cfg_bursts;
                  frames_q   <= (cfg_frames == '0) ? FRAME_W'(1) : cfg_frames;
                  gap_q      <= cfg_gap;
                  burst_cnt  <= '0;
                  frame_cnt  <= '0;
                  state      <= (cfg_bursts == '0) ? DONE : LAUNCH;
                  stim_start <= (cfg_bursts != '0);
               end
               LAUNCH: state <= RUN;
               RUN: if (eof) begin
                  if (frame_nxt == frames_q) begin
                     frame_cnt <= '0;
                     burst_cnt <= burst_nxt;
                     if (burst_nxt == bursts_q) begin
                        state <= DONE;
                     end else if (gap_q == '0) begin
                        state      <= LAUNCH;
                        stim_start <= 1'b1;
                     end else begin
                        state   <= GAP;
                        gap_cnt <= gap_q;
                     end
                  end else begin
                     frame_cnt <= frame_nxt;
                  end
               end else if (wd_hit) begin
                  state <= DONE;
               end
               GAP: if (gap_cnt == GAP_W'(1)) begin
                  state      <= LAUNCH;
                  stim_start <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
               DONE: begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef STIM_CTRL_WATCHDOG_EN
   localparam int SW = $clog2(TIMEOUT_CYCLES + 1);

   logic [SW-1:0] stall;

   assign wd_hit = !hs && (stall == SW'(TIMEOUT_CYCLES - 1));

   // stall counter runs only in RUN; err is sticky until the next accepted go
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall <= '0;
         err   <= 1'b0;
      end else begin
         stall <= (state == RUN && !hs) ? stall + 1'b1 : '0;
         err   <= go_ok ? 1'b0 : (state == RUN && wd_hit && !abort) ? 1'b1 : err;
      end
   end
`else
   assign wd_hit = 1'b0;
   assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_axis_stim_seq_ctrl.sv
// tb_axis_stim_seq_ctrl: scoreboard bench for the burst sequencer with a simple generator model
module tb_axis_stim_seq_ctrl;

   localparam int BW = 16;
   localparam int FW = 8;
   localparam int GW = 16;

   typedef struct {
      int cyc;
      int bcnt;
      int err;
   } done_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          go = 1'b0;
   logic          abort = 1'b0;
   logic [BW-1:0] cfg_bursts = '0;
   logic [FW-1:0] cfg_frames = '0;
   logic [GW-1:0] cfg_gap = '0;
   logic          mon_tvalid = 1'b0;
   logic          mon_tready = 1'b1;
   logic          mon_tlast = 1'b0;
   logic          stim_start;
   logic          busy;
   logic          done;
   logic [BW-1:0] burst_cnt;
   logic [FW-1:0] frame_cnt;
   logic          err;

   int    cyc = 0;
   int    n_cmp = 0;
   int    n_bad = 0;
   int    gen_frames = 1;
   int    gen_beats = 1;
   bit    gen_late = 1'b0;
   int    start_q[$];
   done_t done_q[$];
   done_t de;
   int    g0;

   axis_stim_seq_ctrl #(
      .BURST_W(BW),
      .FRAME_W(FW),
      .GAP_W(GW),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .go(go),
      .abort(abort),
      .cfg_bursts(cfg_bursts),
      .cfg_frames(cfg_frames),
      .cfg_gap(cfg_gap),
      .stim_start(stim_start),
      .mon_tvalid(mon_tvalid),
      .mon_tready(mon_tready),
      .mon_tlast(mon_tlast),
      .busy(busy),
      .done(done),
      .burst_cnt(burst_cnt),
      .frame_cnt(frame_cnt),
      .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push_done(input int c, input int b, input int e);
      done_t t;
      t.cyc  = c;
      t.bcnt = b;
      t.err  = e;
      done_q.push_back(t);
   endtask

   // generator model: one beat per cycle after each start pulse, optional stray tlast beat afterwards
   initial forever begin
      @(negedge clk);
      if (stim_start && !rst) begin
         for (int f = 0; f < gen_frames; f++)
            for (int b = 0; b < gen_beats; b++) begin
               @(posedge clk);
               #1 mon_tvalid = 1'b1;
               mon_tlast = (b == gen_beats - 1);
            end
         if (gen_late) begin
            @(posedge clk);
            #1 mon_tlast = 1'b1;
         end
         @(posedge clk);
         #1 mon_tvalid = 1'b0;
         mon_tlast = 1'b0;
      end
   end

   // monitor: pops expectations whenever the DUT pulses stim_start or done
   initial forever begin
      @(negedge clk);
      if (stim_start) begin
         if (start_q.size() == 0) check("start_unexpected", cyc, -1);
         else check("start_cycle", cyc, start_q.pop_front());
      end
      if (done) begin
         if (done_q.size() == 0) begin
            check("done_unexpected", cyc, -1);
         end else begin
            de = done_q.pop_front();
            check("done_cycle", cyc, de.cyc);
            check("done_burst_cnt", burst_cnt, de.bcnt);
            check("done_err", err, de.err);
            check("done_busy", busy, 0);
         end
      end
   end

   // issues go and pushes the expected start/done timeline; full=0 pushes only the first start
   task automatic run_seq(input int n, input int f, input int g, input int b, input bit full, output int gc);
      int fe;
      int s;
      fe         = (f == 0) ? 1 : f;
      gen_frames = fe;
      gen_beats  = b;
      @(posedge clk);
      #1 go = 1'b1;
      cfg_bursts = BW'(n);
      cfg_frames = FW'(f);
      cfg_gap    = GW'(g);
      gc         = cyc;
      s          = gc + 1;
      if (!full) begin
         start_q.push_back(s);
      end else if (n == 0) begin
         push_done(gc + 2, 0, 0);
      end else begin
         for (int k = 0; k < n; k++) begin
            start_q.push_back(s);
            if (k < n - 1) s += fe * b + 1 + g;
         end
         push_done(s + fe * b + 2, n, 0);
      end
      @(posedge clk);
      #1 go = 1'b0;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input string nm);
      int t;
      t = 0;
      while ((start_q.size() != 0 || done_q.size() != 0) && t < 500) begin
         @(posedge clk);
         t++;
      end
      check({nm, "_pending"}, start_q.size() + done_q.size(), 0);
      start_q.delete();
      done_q.delete();
      repeat (4) @(posedge clk);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_stim_start", stim_start, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_burst_cnt", burst_cnt, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_err", err, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      gen_late = 1'b1;
      run_seq(3, 2, 5, 2, 1'b1, g0);
      drain("t1");
      gen_late = 1'b0;
      check("t1_burst_cnt", burst_cnt, 3);
      check("t1_frame_cnt", frame_cnt, 0);
      check("t1_busy", busy, 0);

      run_seq(2, 1, 0, 1, 1'b1, g0);
      drain("t2");
      check("t2_burst_cnt", burst_cnt, 2);

      run_seq(0, 4, 0, 1, 1'b1, g0);
      @(negedge clk);
      check("t3_busy_hi", busy, 1);
      @(negedge clk);
      check("t3_busy_lo", busy, 0);
      drain("t3");

      run_seq(4, 1, 5, 1, 1'b0, g0);
      wait_until(g0 + 4);
      check("t4_busy_gap", busy, 1);
      check("t4_cnt_gap", burst_cnt, 1);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      check("t4_busy_after_abort", busy, 0);
      check("t4_burst_cnt", burst_cnt, 1);
      repeat (14) @(posedge clk);
      drain("t4");
      check("t4_burst_hold", burst_cnt, 1);

      run_seq(2, 2, 3, 3, 1'b1, g0);
      wait_until(g0 + 3);
      go = 1'b1;
      cfg_bursts = BW'(7);
      cfg_frames = FW'(1);
      cfg_gap    = GW'(0);
      @(posedge clk);
      #1 go = 1'b0;
      drain("t5");
      check("t5_burst_cnt", burst_cnt, 2);

      run_seq(2, 0, 2, 1, 1'b1, g0);
      drain("t6");
      check("t6_burst_cnt", burst_cnt, 2);

      run_seq(2, 2, 0, 2, 1'b0, g0);
      wait_until(g0 + 5);
      check("t7_frame_cnt_pre", frame_cnt, 1);
      check("t7_busy_pre", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("t7_rst_busy", busy, 0);
      check("t7_rst_frame_cnt", frame_cnt, 0);
      check("t7_rst_burst_cnt", burst_cnt, 0);
      check("t7_rst_stim_start", stim_start, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      drain("t7");

`ifdef STIM_CTRL_WATCHDOG_EN
      mon_tready = 1'b0;
      run_seq(1, 1, 0, 1, 1'b0, g0);
      push_done(g0 + 19, 0, 1);
      drain("t8");
      check("t8_err_sticky", err, 1);
      mon_tready = 1'b1;
      run_seq(1, 1, 0, 1, 1'b1, g0);
      check("t8_err_cleared", err, 0);
      drain("t8b");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: actual %0d required %0d", cyc, 0);
      $fatal(1, "bench did not terminate");
   end

endmodule
